// File: rtl/brg_gcd_xcel_pkg.sv
// Shared definitions for the GCD slave accelerator: CSR indices, FSM states
// and STATUS bit positions.
package brg_gcd_xcel_pkg;

    localparam logic [2:0] csr_go_gp     = 3'd0;
    localparam logic [2:0] csr_opa_gp    = 3'd1;
    localparam logic [2:0] csr_opb_gp    = 3'd2;
    localparam logic [2:0] csr_result_gp = 3'd3;
    localparam logic [2:0] csr_status_gp = 3'd4;
    localparam logic [2:0] csr_cycles_gp = 3'd5;

    localparam int status_busy_bit_gp = 0;
    localparam int status_done_bit_gp = 1;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_calc = 2'd1,
        e_done = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/brg_gcd_xcel_unit.sv
// Iterative subtract/swap Euclid engine: one step per cycle on private copies
// of the operands, with a saturating cycle counter.
module brg_gcd_xcel_unit
    import brg_gcd_xcel_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               result_read_i,
    input  logic [width_p-1:0] opa_i,
    input  logic [width_p-1:0] opb_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [width_p-1:0] result_o,
    output logic [width_p-1:0] cycles_o
);

    gcd_state_e         state_r, state_n;
    logic [width_p-1:0] a_r, a_n;
    logic [width_p-1:0] b_r, b_n;
    logic [width_p-1:0] result_r, result_n;
    logic [width_p-1:0] cycles_r, cycles_n;

    // NOTE: every register gets an explicit reset value so a mid-computation
    // reset discards all working state, not just the FSM.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= e_idle;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cycles_r <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state advances together
            // from the values sampled at this edge.
            state_r  <= state_n;
            a_r      <= a_n;
            b_r      <= b_n;
            result_r <= result_n;
            cycles_r <= cycles_n;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a variable
        // unassigned and infers a latch.
        state_n  = state_r;
        a_n      = a_r;
        b_n      = b_r;
        result_n = result_r;
        cycles_n = cycles_r;
        unique case (state_r)
            e_idle, e_done: begin
                if (start_i) begin
                    a_n      = opa_i;
                    b_n      = opb_i;
                    cycles_n = '0;
                    state_n  = e_calc;
                end else if (state_r == e_done && result_read_i) begin
                    state_n = e_idle;
                end
            end
            e_calc: begin
                cycles_n = (cycles_r == '1) ? cycles_r : cycles_r + 1'b1;
                if (b_r == '0) begin
                    result_n = a_r;
                    state_n  = e_done;
                end else if (a_r < b_r) begin
                    a_n = b_r;
                    b_n = a_r;
                end else begin
                    a_n = a_r - b_r;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    assign busy_o   = (state_r == e_calc);
    assign done_o   = (state_r == e_done);
    assign result_o = result_r;
    assign cycles_o = cycles_r;

endmodule

// File: rtl/brg_gcd_slave_xcel.sv
// Endpoint-facing GCD slave: CSR decode, byte-masked operand registers,
// RESULT-read stall while computing, and a one-cycle registered response.
module brg_gcd_slave_xcel
    import brg_gcd_xcel_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      in_v_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic [addr_width_p-1:0]   in_addr_i,
    input  logic                      in_we_i,
    input  logic [data_width_p/8-1:0] in_mask_i,
    output logic                      in_yumi_o,
    output logic                      returning_v_o,
    output logic [data_width_p-1:0]   returning_data_o,
    output logic                      done_o
);

    localparam int mask_width_lp = data_width_p / 8;

    logic [2:0]              csr_idx;
    logic                    unused_addr_hi;
    logic                    stall;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    busy;
    logic                    done;
    logic [data_width_p-1:0] opa_r;
    logic [data_width_p-1:0] opb_r;
    logic [data_width_p-1:0] result;
    logic [data_width_p-1:0] cycles;
    logic [data_width_p-1:0] rd_data;
    logic                    returning_v_r;
    logic [data_width_p-1:0] returning_data_r;

    assign csr_idx        = in_addr_i[2:0];
    assign unused_addr_hi = ^in_addr_i[addr_width_p-1:3];

    // A RESULT read cannot complete until the engine has produced a result.
    assign stall     = in_v_i & ~in_we_i & (csr_idx == csr_result_gp) & busy;
    assign in_yumi_o = in_v_i & ~stall;
    assign wr_fire   = in_yumi_o & in_we_i;
    assign rd_fire   = in_yumi_o & ~in_we_i;

    brg_gcd_xcel_unit #(
        .width_p (data_width_p)
    ) unit (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (wr_fire && csr_idx == csr_go_gp),
        .result_read_i (rd_fire && csr_idx == csr_result_gp),
        .opa_i         (opa_r),
        .opb_i         (opb_r),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .cycles_o      (cycles)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            opa_r <= '0;
            opb_r <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < mask_width_lp; i++) begin
                if (in_mask_i[i] && csr_idx == csr_opa_gp)
                    opa_r[8*i +: 8] <= in_data_i[8*i +: 8];
                if (in_mask_i[i] && csr_idx == csr_opb_gp)
                    opb_r[8*i +: 8] <= in_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (csr_idx)
            csr_go_gp:     rd_data[status_busy_bit_gp] = busy;
            csr_opa_gp:    rd_data = opa_r;
            csr_opb_gp:    rd_data = opb_r;
            csr_result_gp: rd_data = result;
            csr_status_gp: begin
                rd_data[status_busy_bit_gp] = busy;
                rd_data[status_done_bit_gp] = done;
            end
            csr_cycles_gp: rd_data = cycles;
            default:       rd_data = '0;
        endcase
    end

    // Read data is captured from pre-update register values; writes answer 0.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            returning_v_r    <= 1'b0;
            returning_data_r <= '0;
        end else begin
            returning_v_r    <= in_yumi_o;
            returning_data_r <= rd_fire ? rd_data : '0;
        end
    end

    assign returning_v_o    = returning_v_r;
    assign returning_data_o = returning_data_r;
    assign done_o           = done;

endmodule

// File: tb/tb_brg_gcd_slave_xcel.sv
// Directed bench for brg_gcd_slave_xcel: CSR access, GCD results and cycle
// counts, RESULT stall, byte masks, back-to-back traffic and async reset.
module tb_brg_gcd_slave_xcel;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        in_v_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic [31:0] in_addr_i = '0;
    logic        in_we_i = 1'b0;
    logic [3:0]  in_mask_i = '0;
    logic        in_yumi_o;
    logic        returning_v_o;
    logic [31:0] returning_data_o;
    logic        done_o;

    int vectors = 0;
    int miscompares = 0;

    brg_gcd_slave_xcel #(
        .data_width_p (32),
        .addr_width_p (32)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .in_v_i           (in_v_i),
        .in_data_i        (in_data_i),
        .in_addr_i        (in_addr_i),
        .in_we_i          (in_we_i),
        .in_mask_i        (in_mask_i),
        .in_yumi_o        (in_yumi_o),
        .returning_v_o    (returning_v_o),
        .returning_data_o (returning_data_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at a negedge; returns at the negedge after the request was consumed,
    // with that cycle's response sampled. stalls counts cycles without yumi.
    task automatic do_req(input logic we, input logic [2:0] idx, input logic [31:0] data,
                          input logic [3:0] mask, output logic rv, output logic [31:0] rd,
                          output int stalls, output logic early_v);
        in_v_i    = 1'b1;
        in_we_i   = we;
        in_addr_i = {29'd0, idx};
        in_data_i = data;
        in_mask_i = mask;
        stalls    = 0;
        early_v   = 1'b0;
        rv        = 1'b0;
        rd        = '0;
        #1;
        while (in_yumi_o !== 1'b1 && stalls < 200) begin
            @(negedge clk_i);
            stalls++;
            if (returning_v_o !== 1'b0) early_v = 1'b1;
            #1;
        end
        if (stalls < 200) begin
            @(negedge clk_i);
            rv = returning_v_o;
            rd = returning_data_o;
        end else begin
            @(negedge clk_i);
        end
        in_v_i = 1'b0;
    endtask

    task automatic test_reset();
        logic rv; logic [31:0] rd; int st; logic ev;
        in_v_i = 1'b1; in_we_i = 1'b0; in_addr_i = {29'd0, 3'd3};
        #1;
        vectors++;
        if (in_yumi_o !== 1'b1 || returning_v_o !== 1'b0 || returning_data_o !== 32'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: yumi=%b rv=%b rdata=%h done=%b, want 1 0 0 0",
                     in_yumi_o, returning_v_o, returning_data_o, done_o);
        end
        in_v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 3'(i), 32'd0, 4'h0, rv, rd, st, ev);
            vectors++;
            if (rv !== 1'b1 || rd !== 32'd0 || st != 0) begin
                miscompares++;
                $display("FAIL reset_csr%0d: rv=%b data=%h stalls=%0d, want 1 0 0", i, rv, rd, st);
            end
        end
    endtask

    task automatic test_basic();
        logic rv; logic [31:0] rd; int st; logic ev;
        logic [31:0] exp_status [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        do_req(1'b1, 3'd1, 32'd15, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'd5, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'hDEAD_BEEF, 4'hF, rv, rd, st, ev);
        vectors++;
        if (rv !== 1'b1 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL go_write_resp: rv=%b data=%h, want 1 0", rv, rd);
        end
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 3'd4, 32'd0, 4'h0, rv, rd, st, ev);
            vectors++;
            if (rv !== 1'b1 || rd !== exp_status[i]) begin
                miscompares++;
                $display("FAIL status_poll%0d: rv=%b data=%h, want 1 %h", i, rv, rd, exp_status[i]);
            end
        end
        vectors++;
        if (done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL done_level: got %b want 1", done_o);
        end
        do_req(1'b0, 3'd5, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'd5) begin
            miscompares++;
            $display("FAIL basic_cycles: got %0d want 5", rd);
        end
        do_req(1'b0, 3'd0, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++;
            $display("FAIL go_read_done: got %h want 0", rd);
        end
        do_req(1'b0, 3'd3, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rv !== 1'b1 || rd !== 32'd5 || st != 0) begin
            miscompares++;
            $display("FAIL basic_result: rv=%b data=%0d stalls=%0d, want 1 5 0", rv, rd, st);
        end
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_clear: got %b want 0", done_o);
        end
    endtask

    // Runs one computation, polling STATUS (bounded) until done.
    task automatic run_gcd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                           input logic [31:0] exp_cyc, input string name);
        logic rv; logic [31:0] rd; int st; logic ev; logic seen;
        do_req(1'b1, 3'd1, a, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, b, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            do_req(1'b0, 3'd4, 32'd0, 4'h0, rv, rd, st, ev);
            if (rd === 32'd2) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_timeout: done never seen, last status %h", name, rd);
        end
        do_req(1'b0, 3'd5, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== exp_cyc) begin
            miscompares++;
            $display("FAIL %s_cycles: got %0d want %0d", name, rd, exp_cyc);
        end
        do_req(1'b0, 3'd3, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== exp_res) begin
            miscompares++;
            $display("FAIL %s_result: got %0d want %0d", name, rd, exp_res);
        end
    endtask

    task automatic test_edges();
        run_gcd(32'd0, 32'd9, 32'd9, 32'd2, "a0_b9");
        run_gcd(32'd7, 32'd0, 32'd7, 32'd1, "a7_b0");
        run_gcd(32'd0, 32'd0, 32'd0, 32'd1, "a0_b0");
    endtask

    task automatic test_restart_from_done();
        logic rv; logic [31:0] rd; int st; logic ev;
        do_req(1'b1, 3'd1, 32'd12, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'd8, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        repeat (8) @(negedge clk_i);
        vectors++;
        if (done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_first_done: done=%b want 1", done_o);
        end
        // New operands and GO while sitting in DONE without reading RESULT.
        run_gcd(32'd9, 32'd6, 32'd3, 32'd6, "restart");
    endtask

    task automatic test_stall();
        logic rv; logic [31:0] rd; int st; logic ev;
        do_req(1'b1, 3'd1, 32'd48, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'd18, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        do_req(1'b0, 3'd3, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (st != 9 || ev !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_len: stalls=%0d early_resp=%b, want 9 0", st, ev);
        end
        vectors++;
        if (rv !== 1'b1 || rd !== 32'd6) begin
            miscompares++;
            $display("FAIL stall_result: rv=%b data=%0d, want 1 6", rv, rd);
        end
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done_clear: got %b want 0", done_o);
        end
        do_req(1'b0, 3'd5, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'd9) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d want 9", rd);
        end
    endtask

    task automatic test_masks_and_calc_writes();
        logic rv; logic [31:0] rd; int st; logic ev;
        do_req(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd1, 32'h0000_1234, 4'b0011, rv, rd, st, ev);
        do_req(1'b0, 3'd1, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'hFFFF_1234) begin
            miscompares++;
            $display("FAIL mask_low: got %h want ffff1234", rd);
        end
        do_req(1'b1, 3'd1, 32'hAB00_0000, 4'b1000, rv, rd, st, ev);
        do_req(1'b0, 3'd1, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'hABFF_1234) begin
            miscompares++;
            $display("FAIL mask_high: got %h want abff1234", rd);
        end
        do_req(1'b1, 3'd1, 32'd48, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'd18, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'h77, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        vectors++;
        if (rv !== 1'b1 || st != 0) begin
            miscompares++;
            $display("FAIL go_in_calc_ack: rv=%b stalls=%0d, want 1 0", rv, st);
        end
        do_req(1'b0, 3'd3, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'd6) begin
            miscompares++;
            $display("FAIL calc_write_result: got %0d want 6", rd);
        end
        do_req(1'b0, 3'd5, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'd9) begin
            miscompares++;
            $display("FAIL calc_write_cycles: got %0d want 9", rd);
        end
        do_req(1'b0, 3'd2, 32'd0, 4'h0, rv, rd, st, ev);
        vectors++;
        if (rd !== 32'h77) begin
            miscompares++;
            $display("FAIL calc_write_opb: got %h want 77", rd);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [31:0] exp;
    } b2b_t;

    task automatic test_back_to_back();
        logic rv; logic [31:0] rd; int st; logic ev;
        b2b_t seq [10];
        seq[0] = '{1'b1, 3'd1, 32'h0000_00A5, 32'd0};
        seq[1] = '{1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0};
        seq[2] = '{1'b0, 3'd6, 32'd0,         32'd0};
        seq[3] = '{1'b1, 3'd7, 32'hCAFE_F00D, 32'd0};
        seq[4] = '{1'b0, 3'd7, 32'd0,         32'd0};
        seq[5] = '{1'b0, 3'd1, 32'd0,         32'h0000_00A5};
        seq[6] = '{1'b1, 3'd2, 32'h0000_003C, 32'd0};
        seq[7] = '{1'b0, 3'd2, 32'd0,         32'h0000_003C};
        seq[8] = '{1'b1, 3'd3, 32'h1111_1111, 32'd0};
        seq[9] = '{1'b0, 3'd4, 32'd0,         32'd0};
        for (int i = 0; i < 10; i++) begin
            do_req(seq[i].we, seq[i].idx, seq[i].data, 4'hF, rv, rd, st, ev);
            vectors++;
            if (rv !== 1'b1 || st != 0 || rd !== seq[i].exp) begin
                miscompares++;
                $display("FAIL b2b%0d: rv=%b stalls=%0d data=%h, want 1 0 %h",
                         i, rv, st, rd, seq[i].exp);
            end
        end
        @(negedge clk_i);
        vectors++;
        if (returning_v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_resp: rv=%b want 0", returning_v_o);
        end
    endtask

    task automatic test_reset_mid();
        logic rv; logic [31:0] rd; int st; logic ev;
        do_req(1'b1, 3'd1, 32'd48, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd2, 32'd18, 4'hF, rv, rd, st, ev);
        do_req(1'b1, 3'd0, 32'd0, 4'hF, rv, rd, st, ev);
        @(negedge clk_i);
        in_v_i = 1'b1; in_we_i = 1'b0; in_addr_i = {29'd0, 3'd1};
        #2;
        reset_i = 1'b0;
        #1;
        vectors++;
        if (in_yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_yumi: got %b want 1", in_yumi_o);
        end
        @(negedge clk_i);
        vectors++;
        if (returning_v_o !== 1'b0 || returning_data_o !== 32'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: rv=%b data=%h done=%b, want 0 0 0",
                     returning_v_o, returning_data_o, done_o);
        end
        in_v_i  = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        for (int i = 1; i < 6; i++) begin
            do_req(1'b0, 3'(i), 32'd0, 4'h0, rv, rd, st, ev);
            vectors++;
            if (rv !== 1'b1 || rd !== 32'd0) begin
                miscompares++;
                $display("FAIL mid_reset_csr%0d: rv=%b data=%h, want 1 0", i, rv, rd);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        test_reset();
        test_basic();
        test_edges();
        test_restart_from_done();
        test_stall();
        test_masks_and_calc_writes();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
